alu_bist_ctrl: RTL

//  Built-in self-test sequencer for the 32-bit ALU. It drives the ALU operand
//  and control inputs from a fixed 8-entry vector ROM, then samples Result and
//  the Zero/Negative/Carry/OverFlow flags and compares them with expected values.
//  It sits beside the ALU in the single-cycle core; bist_active steers the core's
//  ALU input mux to this block. It reports pass/fail and failure details.

---
 rtl/alu_bist_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/alu_bist_ctrl.sv
// alu_bist_ctrl: ROM-driven self-test sequencer that exercises the ALU and scores its outputs
module alu_bist_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter bit          STOP_ON_FAIL  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_negative,
  input  logic        alu_carry,
  input  logic        alu_overflow,
  output logic        bist_active,
  output logic        done,
  output logic        pass,
  output logic [3:0]  fail_count,
  output logic [2:0]  fail_idx
);
  typedef enum logic [2:0] {IDLE, LOAD, DRIVE, CHECK, DONE} state_t;
  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        n;
    logic        c;
    logic        v;
    logic        mc;
    logic        mv;
  } vec_t;
  // mc/mv enable the carry/overflow compare; zero, negative and result are always checked
  function automatic vec_t rom(input logic [2:0] i);
    case (i)
      3'd0:    rom = {3'b000, 32'd5, 32'd3, 32'd8, 6'b0000_11};
      3'd1:    rom = {3'b001, 32'd5, 32'd3, 32'd2, 6'b0000_01};
      3'd2:    rom = {3'b010, 32'd5, 32'd3, 32'd1, 6'b0000_00};
      3'd3:    rom = {3'b011, 32'd5, 32'd3, 32'd7, 6'b0000_00};
      3'd4:    rom = {3'b101, 32'd3, 32'd5, 32'd1, 6'b0000_00};
      3'd5:    rom = {3'b001, 32'd3, 32'd3, 32'd0, 6'b1000_01};
      3'd6:    rom = {3'b001, 32'd3, 32'd5, 32'hFFFF_FFFE, 6'b0100_01};
      default: rom = {3'b000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 6'b0101_11};
    endcase
  endfunction
  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [3:0]  fc_q, fc_d;
  logic [2:0]  fi_q, fi_d;
  logic        done_q, done_d, pass_q, pass_d, act_q, act_d;
  vec_t        cur, nxt;
  logic        miss;
  // compare the ALU against the vector currently on its inputs
  always_comb begin
    cur  = rom(idx_q);
    nxt  = rom(idx_q + 3'd1);
    miss = (alu_result != cur.res) | (alu_zero != cur.z) | (alu_negative != cur.n) |
           (cur.mc & (alu_carry != cur.c)) | (cur.mv & (alu_overflow != cur.v));
  end
  // sequencer next-state and registered outputs
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    ctrl_d  = ctrl_q;
    fc_d    = fc_q;
    fi_d    = fi_q;
    done_d  = done_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = LOAD;
        idx_d   = 3'd0;
        fc_d    = 4'd0;
        fi_d    = 3'd0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end
      LOAD: begin
        state_d = DRIVE;
        cnt_d   = 4'd0;
        {ctrl_d, a_d, b_d} = {rom(3'd0).op, rom(3'd0).a, rom(3'd0).b};
      end
      DRIVE: begin
        state_d = (cnt_q == 4'(SETTLE_CYCLES - 1)) ? CHECK : DRIVE;
        cnt_d   = (cnt_q == 4'(SETTLE_CYCLES - 1)) ? cnt_q : cnt_q + 4'd1;
      end
      CHECK: begin
        fc_d = miss ? fc_q + 4'd1 : fc_q;
        fi_d = (miss && fc_q == 4'd0) ? idx_q : fi_q;
        if ((miss && STOP_ON_FAIL) || idx_q == 3'd7) begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = (fc_d == 4'd0);
        end else begin
          state_d = DRIVE;
          idx_d   = idx_q + 3'd1;
          cnt_d   = 4'd0;
          {ctrl_d, a_d, b_d} = {nxt.op, nxt.a, nxt.b};
        end
      end
      default: state_d = IDLE;
    endcase
    act_d = (state_d == LOAD) || (state_d == DRIVE) || (state_d == CHECK);
  end
  // state and output registers; reset aborts any run in progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      ctrl_q  <= 3'd0;
      fc_q    <= 4'd0;
      fi_q    <= 3'd0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      fc_q    <= fc_d;
      fi_q    <= fi_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      act_q   <= act_d;
    end
  end
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_ctrl    = ctrl_q;
  assign bist_active = act_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_count  = fc_q;
  assign fail_idx    = fi_q;
endmodule
